zymason_loader: RTL and testbench
=================================

Name: zymason_loader

Overview:
- Host-side initiator for the Zymason_Tiny1 digit store. Takes a packed message of NUM_DIGITS 7-bit segment patterns and drives the display's clock, reset, RW, sel and pin_in pins so every digit is written in order.
- Leaves the display in read/scan mode with its position pointer back at digit 0.
- Sits in the host or test fabric and connects directly to the display's io_in[7:0].

Parameters:
- NUM_DIGITS, 10, digits written per load; must match the display's digit count.
- CLK_DIV, 2, loader clock cycles per dev_clk phase (low and high); must be ≥1.
- RST_TICKS, 1, device cycles dev_reset is held at the start of a load; must be ≥1.

Ports:
- clock  in  1  loader clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  single-cycle request; samples msg when accepted.
- msg  in  7*NUM_DIGITS  digit i occupies [7i+6:7i]; bits [7i+3:7i] are the low nibble, [7i+6:7i+4] the high field.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a load completes.
- dev_clk  out  1  display clock (io_in[0]).
- dev_reset  out  1  display reset (io_in[1]).
- dev_rw  out  1  display RW (io_in[2]).
- dev_sel  out  1  display sel (io_in[3]).
- dev_pin  out  4  display pin_in (io_in[7:4]).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
- Reset values: all outputs 0; state IDLE; message register 0.
- Device cycle ("step"): 2*CLK_DIV loader cycles.
  - dev_clk is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles.
  - dev_reset, dev_rw, dev_sel and dev_pin change only on the first cycle of a step (dev_clk low). They are therefore stable for CLK_DIV cycles before and after the display samples on the dev_clk rising edge.
- Start:
  - In IDLE, start=1 latches msg, clears the digit index to 0, and enters RST. The first step begins on the next cycle, when busy rises.
  - start is ignored while busy.
- States, in order:
  - RST, RST_TICKS steps: dev_reset=1, rw=0, sel=0, pin=0.
  - LO: rw=1, sel=0, pin = low nibble of digit i. The display enters or stays in its write-low state and stores the nibble.
  - HI: rw=1, sel=1, pin = {1'b0, high field of digit i}. The display stores bits [6:4].
  - ADV: rw=1, sel=0, pin = low nibble of digit i again.
    - The display advances its position on this edge and also rewrites the current digit's low nibble. Repeating the same nibble keeps that write harmless.
    - If i < NUM_DIGITS-1, increment i and go to LO. Otherwise go to REL.
  - REL, one step: rw=0, sel=0, pin=0. The display returns to scan mode.
  - DONE: done=1 for one cycle, busy falls the same cycle, dev_clk=0, then IDLE.
- Sequence guarantees:
  - Every digit gets exactly LO, HI, ADV; no step is skipped.
  - After NUM_DIGITS ADV steps the display's position pointer has wrapped to digit 0.
- Latency: busy lasts (RST_TICKS + 3*NUM_DIGITS + 1)*2*CLK_DIV cycles, then done pulses on the following cycle.
- Boundaries:
  - A start pulse on the same cycle as done is ignored.
  - Reset mid-load aborts immediately to IDLE with all outputs 0. The display is left partially written; the next load re-resets it.
  - NUM_DIGITS=1: the sequence is RST, LO, HI, ADV, REL.
  - The unused pin bit 3 in HI is always 0.
- Counters:
  - Phase counter is $clog2(CLK_DIV) bits and wraps at CLK_DIV-1.
  - Step counter for RST_TICKS uses the same width rule.
  - Digit index is $clog2(NUM_DIGITS) bits and never exceeds NUM_DIGITS-1.

Decomposition:
- zymason_pkg holds:
  - typedef enum loader_state_t {IDLE, RST, LO, HI, ADV, REL, DONE};
  - SEG_W=7, NIB_W=4, HI_W=3.
- Sub-module zymason_tickgen:
  - Implements the CLK_DIV divider.
  - Outputs dev_clk, plus step_start (one cycle, first cycle of a step) and step_end (last cycle of a step).
  - Runs only while enabled; cleared to phase 0 when disabled.
- The top-level FSM advances only on step_end.

Test Plan:
- Single load, CLK_DIV=2, msg digit k = 7'h10+k:
  - the pin sequence sampled at dev_clk rising edges after reset is 0,(k,1,k) for k=0..9, then REL;
  - busy is high for 128 cycles; done pulses once.
- Digit 7'h7F: HI step pin=4'b0111 and LO/ADV pin=4'hF; the display model's readback of that digit is 7'h7F.
- Scoreboard against a behavioural display model:
  - all 10 digits read back equal msg;
  - the model's position pointer is 0 and its FSM is in scan after REL.
- start held high for 200 cycles: exactly one load occurs and one done pulse; a second start after done launches a new load.
- Reset asserted during HI of digit 4: the next cycle all outputs are 0 and busy=0; a following start completes a full correct load.
- Corner parameters:
  - CLK_DIV=1, NUM_DIGITS=1, RST_TICKS=3 gives busy = (3+3+1)*2 = 14 cycles;
  - dev_clk toggles every cycle; no pin change coincides with a rising dev_clk edge.

Source files
------------

// File: rtl/zymason_pkg.sv
// Shared state encoding, field widths and pin bundle for the Zymason_Tiny1 loader.
package zymason_pkg;

   typedef enum logic [2:0] {IDLE, RST, LO, HI, ADV, REL, DONE} loader_state_t;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;
   localparam int unsigned HI_W  = 3;

   // Display-side pins that are held constant for a whole device step.
   typedef struct packed {
      logic             rst;
      logic             rw;
      logic             sel;
      logic [NIB_W-1:0] pin;
   } dev_pins_t;

   // Counter width with a one-bit floor so a value of 1 still gets a real register.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zymason_tickgen.sv
// Device-step timing: CLK_DIV cycles of dev_clk low then CLK_DIV cycles high,
// with strobes on the first and last cycle of each step.
module zymason_tickgen
   import zymason_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
)
(
   input  logic clock,
   input  logic reset,
   input  logic en,
   output logic dev_clk,
   output logic step_start,
   output logic step_end
);

   localparam int unsigned     PH_W    = cnt_w(CLK_DIV);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

   logic [PH_W-1:0] phase_q, phase_d;
   logic            half_q, half_d;

   always_comb begin
      phase_d = phase_q;
      half_d  = half_q;
      if (!en) begin
         phase_d = '0;
         half_d  = 1'b0;
      end else if (phase_q == PH_LAST) begin
         phase_d = '0;
         half_d  = !half_q;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= '0;
         half_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         half_q  <= half_d;
      end
   end

   assign dev_clk    = half_q;
   assign step_start = en && !half_q && (phase_q == '0);
   assign step_end   = en &&  half_q && (phase_q == PH_LAST);

endmodule

// File: rtl/zymason_loader.sv
// Host-side loader: resets the Zymason_Tiny1 display, writes every digit as
// LO/HI/ADV steps, then releases it to scan mode with the pointer back at 0.
module zymason_loader
   import zymason_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 10,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned RST_TICKS  = 1
)
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [SEG_W*NUM_DIGITS-1:0] msg,
   output logic                        busy,
   output logic                        done,
   output logic                        dev_clk,
   output logic                        dev_reset,
   output logic                        dev_rw,
   output logic                        dev_sel,
   output logic [NIB_W-1:0]            dev_pin
);

   localparam int unsigned      IDX_W    = cnt_w(NUM_DIGITS);
   localparam int unsigned      RC_W     = cnt_w(RST_TICKS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_TICKS - 1);

   loader_state_t               state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [RC_W-1:0]             rcnt_q, rcnt_d;
   logic [SEG_W*NUM_DIGITS-1:0] msg_q, msg_d;
   dev_pins_t                   pins_q, pins_d, dec;
   logic [SEG_W-1:0]            cur;
   logic                        step_start, step_end;

   zymason_tickgen #(.CLK_DIV(CLK_DIV)) u_tickgen (
      .clock      (clock),
      .reset      (reset),
      .en         (busy),
      .dev_clk    (dev_clk),
      .step_start (step_start),
      .step_end   (step_end)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rcnt_q  <= '0;
         msg_q   <= '0;
         pins_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rcnt_q  <= rcnt_d;
         msg_q   <= msg_d;
         pins_q  <= pins_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rcnt_d  = rcnt_q;
      msg_d   = msg_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = RST;
            msg_d   = msg;
            idx_d   = '0;
            rcnt_d  = '0;
         end
         RST: if (step_end) begin
            if (rcnt_q == RC_LAST) state_d = LO;
            else                   rcnt_d  = rcnt_q + 1'b1;
         end
         LO:  if (step_end) state_d = HI;
         HI:  if (step_end) state_d = ADV;
         ADV: if (step_end) begin
            if (idx_q == IDX_LAST) begin
               state_d = REL;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = LO;
            end
         end
         REL:  if (step_end) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pins are decoded once at step start and held, so they never move while dev_clk is high.
   always_comb begin
      cur = msg_q[SEG_W*idx_q +: SEG_W];
      dec = '0;
      unique case (state_q)
         RST: dec.rst = 1'b1;
         LO, ADV: begin
            dec.rw  = 1'b1;
            dec.pin = cur[NIB_W-1:0];
         end
         HI: begin
            dec.rw  = 1'b1;
            dec.sel = 1'b1;
            dec.pin = {{(NIB_W-HI_W){1'b0}}, cur[NIB_W +: HI_W]};
         end
         default: ;
      endcase
      pins_d = step_start ? dec : pins_q;
   end

   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign done      = (state_q == DONE);
   assign dev_reset = pins_d.rst;
   assign dev_rw    = pins_d.rw;
   assign dev_sel   = pins_d.sel;
   assign dev_pin   = pins_d.pin;

endmodule

// File: tb/tb_zymason_loader.sv
// Randomized bench for zymason_loader: default and corner-parameter instances,
// each driving a behavioural model of the Zymason_Tiny1 digit store.
module tb_zymason_loader;

   localparam int N   = 10;
   localparam int CD  = 2;
   localparam int RT  = 1;
   localparam int CN  = 1;
   localparam int CCD = 1;
   localparam int CRT = 3;
   localparam int MW  = 7 * N;
   localparam int SCAN = 0, WLO = 1, WHI = 2;

   typedef logic [6:0] step_t;   // {reset, rw, sel, pin[3:0]} at a dev_clk rise
   typedef step_t step_q_t[$];

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset, start, busy, done, dev_clk, dev_reset, dev_rw, dev_sel;
   logic [MW-1:0] msg;
   logic [3:0]    dev_pin;
   logic          c_reset, c_start, c_busy, c_done, c_dev_clk, c_dev_reset, c_dev_rw, c_dev_sel;
   logic [6:0]    c_msg;
   logic [3:0]    c_dev_pin;

   zymason_loader #(.NUM_DIGITS(N), .CLK_DIV(CD), .RST_TICKS(RT)) u_dut (
      .clock(clock), .reset(reset), .start(start), .msg(msg), .busy(busy), .done(done),
      .dev_clk(dev_clk), .dev_reset(dev_reset), .dev_rw(dev_rw), .dev_sel(dev_sel),
      .dev_pin(dev_pin)
   );

   zymason_loader #(.NUM_DIGITS(CN), .CLK_DIV(CCD), .RST_TICKS(CRT)) u_dut_corner (
      .clock(clock), .reset(c_reset), .start(c_start), .msg(c_msg), .busy(c_busy),
      .done(c_done), .dev_clk(c_dev_clk), .dev_reset(c_dev_reset), .dev_rw(c_dev_rw),
      .dev_sel(c_dev_sel), .dev_pin(c_dev_pin)
   );

   int n_vec = 0;
   int n_err = 0;

   // index 0 = default instance, 1 = corner instance
   step_q_t    seq0, seq1;
   logic [6:0] dmem [2][N];
   int         dpos [2], dmode [2], dnd [2];
   int         busy_cnt [2], done_cnt [2], sel_rise [2];
   logic       pclk [2];
   logic       pbusy [2];
   step_t      ppins [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [MW-1:0] rnd_msg();
      return MW'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic disp_edge(input int d, input step_t p);
      if (p[6]) begin
         dpos[d]  = 0;
         dmode[d] = SCAN;
      end else if (!p[5]) begin
         dmode[d] = SCAN;
      end else if (p[4]) begin
         dmem[d][dpos[d]][6:4] = p[2:0];
         dmode[d] = WHI;
      end else begin
         dmem[d][dpos[d]][3:0] = p[3:0];
         if (dmode[d] == WHI) dpos[d] = (dpos[d] + 1) % dnd[d];
         dmode[d] = WLO;
      end
   endtask

   task automatic observe(input int d, input logic b, input logic dn, input logic ck,
                          input step_t p);
      if (b)  busy_cnt[d]++;
      if (dn) done_cnt[d]++;
      if (d == 1 && b && pbusy[d]) chk("c_clk_toggle", 32'(ck), 32'(!pclk[d]));
      if (ck && !pclk[d]) begin
         chk("pins_stable_at_rise", 32'(p), 32'(ppins[d]));
         if (d == 0) seq0.push_back(p);
         else        seq1.push_back(p);
         if (p[4]) sel_rise[d]++;
         disp_edge(d, p);
      end
      pclk[d]  = ck;
      pbusy[d] = b;
      ppins[d] = p;
   endtask

   task automatic tick();
      @(negedge clock);
      observe(0, busy, done, dev_clk, {dev_reset, dev_rw, dev_sel, dev_pin});
      observe(1, c_busy, c_done, c_dev_clk, {c_dev_reset, c_dev_rw, c_dev_sel, c_dev_pin});
   endtask

   function automatic step_q_t exp_seq(input int rt, input int nd, input logic [MW-1:0] m);
      step_q_t    q;
      logic [6:0] dg;
      for (int i = 0; i < rt; i++) q.push_back(7'b100_0000);
      for (int k = 0; k < nd; k++) begin
         dg = m[7*k +: 7];
         q.push_back({3'b010, dg[3:0]});
         q.push_back({3'b011, 1'b0, dg[6:4]});
         q.push_back({3'b010, dg[3:0]});
      end
      q.push_back(7'b000_0000);
      return q;
   endfunction

   task automatic verify(input int d, input string tag, input logic [MW-1:0] m,
                         input int bexp, input step_q_t got);
      step_q_t e;
      e = exp_seq((d == 0) ? RT : CRT, dnd[d], m);
      chk({tag, "_busy_len"}, busy_cnt[d], bexp);
      chk({tag, "_done_cnt"}, done_cnt[d], 1);
      chk({tag, "_steps"}, got.size(), e.size());
      for (int i = 0; i < e.size() && i < got.size(); i++)
         chk({tag, "_step"}, 32'(got[i]), 32'(e[i]));
      for (int k = 0; k < dnd[d]; k++)
         chk({tag, "_readback"}, 32'(dmem[d][k]), 32'(m[7*k +: 7]));
      chk({tag, "_pos"}, dpos[d], 0);
      chk({tag, "_mode"}, dmode[d], SCAN);
   endtask

   task automatic load_main(input string tag, input logic [MW-1:0] m);
      int t;
      seq0.delete();
      busy_cnt[0] = 0;
      done_cnt[0] = 0;
      msg   = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      msg   = rnd_msg();
      t = 0;
      while (!done && t < 5000) begin tick(); t++; end
      chk({tag, "_no_timeout"}, 32'(t < 5000), 32'd1);
      tick();
      chk({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
      verify(0, tag, m, (RT + 3*N + 1) * 2 * CD, seq0);
   endtask

   task automatic load_corner(input string tag, input logic [6:0] m);
      int t;
      logic [MW-1:0] mm;
      seq1.delete();
      busy_cnt[1] = 0;
      done_cnt[1] = 0;
      c_msg   = m;
      c_start = 1'b1;
      tick();
      c_start = 1'b0;
      c_msg   = 7'($urandom());
      t = 0;
      while (!c_done && t < 500) begin tick(); t++; end
      chk({tag, "_no_timeout"}, 32'(t < 500), 32'd1);
      tick();
      chk({tag, "_idle_after"}, 32'({c_busy, c_done}), 32'd0);
      mm      = '0;
      mm[6:0] = m;
      verify(1, tag, mm, (CRT + 3*CN + 1) * 2 * CCD, seq1);
   endtask

   initial begin
      logic [MW-1:0] m;
      int            t, j;
      logic          prev_done;

      for (int d = 0; d < 2; d++) begin
         dpos[d] = 0; dmode[d] = SCAN; busy_cnt[d] = 0; done_cnt[d] = 0;
         sel_rise[d] = 0; pclk[d] = 1'b0; pbusy[d] = 1'b0; ppins[d] = '0;
         for (int k = 0; k < N; k++) dmem[d][k] = '0;
      end
      dnd[0] = N;
      dnd[1] = CN;
      reset = 1'b1; c_reset = 1'b1; start = 1'b0; c_start = 1'b0;
      msg = '0; c_msg = '0;
      repeat (3) tick();
      chk("reset_outs", 32'({busy, done, dev_clk, dev_reset, dev_rw, dev_sel, dev_pin}), 32'd0);
      chk("c_reset_outs",
          32'({c_busy, c_done, c_dev_clk, c_dev_reset, c_dev_rw, c_dev_sel, c_dev_pin}), 32'd0);
      reset = 1'b0;
      c_reset = 1'b0;
      tick();

      m = '0;
      for (int k = 0; k < N; k++) m[7*k +: 7] = 7'(8'h10 + k);
      load_main("ramp", m);

      m = rnd_msg();
      m[7*3 +: 7] = 7'h7F;
      load_main("d7f", m);
      chk("d7f_lo_pin",  32'(seq0[RT + 9][3:0]),  32'hF);
      chk("d7f_hi_pin",  32'(seq0[RT + 10][3:0]), 32'b0111);
      chk("d7f_adv_pin", 32'(seq0[RT + 11][3:0]), 32'hF);

      for (int r = 0; r < 4; r++) begin
         m = rnd_msg();
         j = int'($urandom_range(N - 1));
         m[7*j +: 7] = 7'h7F;
         load_main("rand", m);
      end

      // start held high: one completion in the window, start on the done cycle ignored
      done_cnt[0] = 0;
      msg   = rnd_msg();
      start = 1'b1;
      prev_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (prev_done) chk("start_at_done_ignored", 32'(busy), 32'd0);
         prev_done = done;
      end
      chk("held_one_done", done_cnt[0], 1);
      start = 1'b0;
      t = 0;
      while (!done && t < 5000) begin tick(); t++; end
      chk("held_second_no_timeout", 32'(t < 5000), 32'd1);
      tick();
      load_main("after_held", rnd_msg());

      // abort during HI of digit 4
      sel_rise[0] = 0;
      msg   = rnd_msg();
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (sel_rise[0] < 5 && t < 5000) begin tick(); t++; end
      chk("hi4_reached", 32'(t < 5000), 32'd1);
      chk("in_hi4", 32'({busy, dev_sel}), 32'b11);
      reset = 1'b1;
      tick();
      chk("abort_outs", 32'({busy, done, dev_clk, dev_reset, dev_rw, dev_sel, dev_pin}), 32'd0);
      reset = 1'b0;
      tick();
      load_main("post_abort", rnd_msg());

      load_corner("c_rand", 7'($urandom()));
      load_corner("c_7f", 7'h7F);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
